// File: rtl/abm_pkg.sv
// abm_pkg: AXI response codes, scheduler state encoding and ABM table geometry
package abm_pkg;
    localparam logic [1:0] AXI_OKAY   = 2'd0;
    localparam logic [1:0] AXI_SLVERR = 2'd2;
    localparam logic [1:0] AXI_DECERR = 2'd3;
    localparam int ABM_ENTRY_BYTES    = 8;
    typedef enum logic [1:0] {IDLE, ADDR, RESP} state_t;
endpackage

// File: rtl/abm_rr_arbiter.sv
// abm_rr_arbiter: combinational round-robin pick, first set request searching upward from ptr with wrap
module abm_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);
    logic [IDX_W-1:0] j;
    // Scanning from the far end lets the candidate nearest ptr overwrite the others.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        j = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = IDX_W'((int'(ptr_i) + k) % NUM_REQ);
            if (req_i[j]) begin
                gnt_o = '0;
                gnt_o[j] = 1'b1;
                idx_o = j;
            end
        end
    end
    assign any_o = |req_i;
endmodule

// File: rtl/abm_write_sched.sv
// abm_write_sched: round-robin scheduler posting requester status words to the host ABM table
// through a single-beat, single-outstanding AXI4 write port.
module abm_write_sched
    import abm_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [63:0]           abm_host_addr,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [64*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic                  busy,
    output logic [15:0]           err_count,
    output logic [63:0]           M_AXI_AWADDR,
    output logic [7:0]            M_AXI_AWLEN,
    output logic [2:0]            M_AXI_AWSIZE,
    output logic [1:0]            M_AXI_AWBURST,
    output logic                  M_AXI_AWVALID,
    input  logic                  M_AXI_AWREADY,
    output logic [63:0]           M_AXI_WDATA,
    output logic [7:0]            M_AXI_WSTRB,
    output logic                  M_AXI_WLAST,
    output logic                  M_AXI_WVALID,
    input  logic                  M_AXI_WREADY,
    input  logic [1:0]            M_AXI_BRESP,
    input  logic                  M_AXI_BVALID,
    output logic                  M_AXI_BREADY
);
    state_t state_q, state_d;
    logic [NUM_REQ-1:0] ready_q, ready_d, gnt;
    logic [IDX_W-1:0] ptr_q, ptr_d, idx;
    logic any_req, grant, aw_done, w_done;
    logic awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic [63:0] awaddr_q, awaddr_d, wdata_q, wdata_d;
    logic [15:0] err_q, err_d;

    abm_rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
        .req_i(req_valid),
        .ptr_i(ptr_q),
        .gnt_o(gnt),
        .idx_o(idx),
        .any_o(any_req)
    );

    // A zero base address disables the block: nothing is granted.
    assign grant   = state_q == IDLE && abm_host_addr != '0 && any_req;
    assign aw_done = !awvalid_q || M_AXI_AWREADY;
    assign w_done  = !wvalid_q || M_AXI_WREADY;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= IDLE;
            ready_q   <= '0;
            ptr_q     <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            ready_q   <= ready_d;
            ptr_q     <= ptr_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d = grant ? ADDR
                : (state_q == ADDR && aw_done && w_done) ? RESP
                : (state_q == RESP && M_AXI_BVALID) ? IDLE
                : state_q;
    end

    always_comb begin
        ready_d   = grant ? gnt : '0;
        awvalid_d = grant || (awvalid_q && !M_AXI_AWREADY);
        wvalid_d  = grant || (wvalid_q && !M_AXI_WREADY);
        bready_d  = (state_q == ADDR && aw_done && w_done) || (bready_q && !M_AXI_BVALID);
        awaddr_d  = grant ? abm_host_addr + 64'(idx) * 64'(ABM_ENTRY_BYTES) : awaddr_q;
        wdata_d   = grant ? 64'(req_data >> {idx, 6'd0}) : wdata_q;
        ptr_d     = grant ? (idx == IDX_W'(NUM_REQ - 1) ? '0 : idx + 1'b1) : ptr_q;
        err_d     = (state_q == RESP && M_AXI_BVALID && M_AXI_BRESP != AXI_OKAY && err_q != 16'hFFFF)
                  ? err_q + 16'd1 : err_q;
    end

    assign req_ready     = ready_q;
    assign busy          = state_q != IDLE;
    assign err_count     = err_q;
    assign M_AXI_AWADDR  = awaddr_q;
    assign M_AXI_AWLEN   = 8'd0;
    assign M_AXI_AWSIZE  = 3'b011;
    assign M_AXI_AWBURST = 2'b01;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = 8'hFF;
    assign M_AXI_WLAST   = 1'b1;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
endmodule

// File: tb/tb_abm_write_sched.sv
// tb_abm_write_sched: directed scenarios against a transaction-level model checked every cycle
module tb_abm_write_sched;
    localparam int N = 4;
    localparam logic [63:0] BASE = 64'h1_0000_0000;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic [63:0] base = '0;
    logic [N-1:0] req_valid = '0;
    logic [64*N-1:0] req_data = '0;
    logic [N-1:0] req_ready;
    logic busy;
    logic [15:0] err_count;
    logic [63:0] awaddr, wdata;
    logic [7:0] awlen, wstrb;
    logic [2:0] awsize;
    logic [1:0] awburst;
    logic awvalid, wvalid, wlast, bready;
    logic awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
    logic [1:0] bresp = 2'd0;

    int tests = 0, fails = 0;
    bit checking = 0, sticky = 0, b_hold = 0, preload = 0;
    int aw_delay = 0, w_delay = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
    logic [1:0] bresp_cfg = 2'd0;

    always #5 clk = ~clk;

    abm_write_sched #(.NUM_REQ(N), .IDX_W(2)) dut (
        .clk(clk), .resetn(resetn), .abm_host_addr(base),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .busy(busy), .err_count(err_count),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen), .M_AXI_AWSIZE(awsize),
        .M_AXI_AWBURST(awburst), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast),
        .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready)
    );

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int pick(logic [N-1:0] r, int p);
        for (int k = 0; k < N; k++)
            if (r[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    function automatic int oh2i(logic [N-1:0] v);
        for (int k = 0; k < N; k++)
            if (v[k]) return k;
        return -1;
    endfunction

    // Slave: ready after a programmable number of valid cycles, B answered as soon as BREADY shows.
    always @(negedge clk) begin
        if (awvalid === 1'b1) begin awready = aw_cnt >= aw_delay; aw_cnt++; end
        else begin awready = 1'b0; aw_cnt = 0; end
        if (wvalid === 1'b1) begin wready = w_cnt >= w_delay; w_cnt++; end
        else begin wready = 1'b0; w_cnt = 0; end
        bvalid = bready === 1'b1 && !b_hold;
        bresp = bresp_cfg;
        if (bvalid && resetn) b_cnt++;
    end

    // Model: one write in flight; a write is an AW beat, a W beat, then one B.
    bit busy_m, awv_m, wv_m, br_m;
    logic [N-1:0] rdy_m;
    logic [63:0] addr_m, data_m;
    logic [15:0] err_m;
    int ptr_m;
    always @(posedge clk) begin
        if (!resetn) begin
            busy_m = 0; awv_m = 0; wv_m = 0; br_m = 0; rdy_m = '0;
            addr_m = '0; data_m = '0; err_m = '0; ptr_m = 0;
        end else begin
            rdy_m = '0;
            if (preload) err_m = 16'hFFFD;
            if (!busy_m) begin
                if (base != 0 && req_valid != 0) begin
                    int g;
                    g = pick(req_valid, ptr_m);
                    rdy_m[g] = 1'b1;
                    addr_m = base + 64'(8 * g);
                    data_m = 64'(req_data >> (64 * g));
                    awv_m = 1; wv_m = 1; busy_m = 1;
                    ptr_m = (g + 1) % N;
                end
            end else if (!br_m) begin
                awv_m = awv_m && !awready;
                wv_m = wv_m && !wready;
                br_m = !awv_m && !wv_m;
            end else if (bvalid) begin
                br_m = 0; busy_m = 0;
                if (bresp != 2'd0 && err_m != 16'hFFFF) err_m = err_m + 16'd1;
            end
        end
    end

    always @(negedge clk) if (checking) begin
        chk("req_ready", 64'(req_ready), 64'(rdy_m));
        chk("busy", 64'(busy), 64'(busy_m));
        chk("awvalid", 64'(awvalid), 64'(awv_m));
        chk("wvalid", 64'(wvalid), 64'(wv_m));
        chk("bready", 64'(bready), 64'(br_m));
        chk("err_count", 64'(err_count), 64'(err_m));
        chk("awaddr", awaddr, addr_m);
        chk("wdata", wdata, data_m);
    end

    task automatic cyc(int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
            if (!sticky) req_valid = req_valid & ~req_ready;
        end
    endtask

    task automatic wait_grant(output int idx);
        idx = -1;
        for (int t = 0; t < 40; t++) begin
            cyc();
            if (req_ready != 0) begin idx = oh2i(req_ready); break; end
        end
        tests++;
        if (idx < 0) begin fails++; $display("FAIL grant_timeout: no req_ready within 40 cycles"); end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int t = 0; t < 60; t++) begin
            cyc();
            if (!busy && req_valid == 0) begin ok = 1; break; end
        end
        tests++;
        if (!ok) begin fails++; $display("FAIL idle_timeout: busy=%b req_valid=%b", busy, req_valid); end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        cyc(2);
        resetn = 1'b1;
        cyc();
    endtask

    task automatic one_write(int r, logic [1:0] resp);
        int g;
        bresp_cfg = resp;
        req_valid[r] = 1'b1;
        wait_grant(g);
        chk("write_index", 64'(g), 64'(r));
        wait_idle();
    endtask

    initial begin
        int g, b0;
        for (int i = 0; i < N; i++) req_data[64*i +: 64] = 64'hA5A5_0000_0000_0000 | 64'(i * 16'h1111);
        req_data[127:64] = 64'hDEAD_BEEF_0123_4567;
        cyc(2);
        checking = 1;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_err", 64'(err_count), 64'd0);
        chk("rst_awaddr", awaddr, 64'd0);
        chk("const_fields", {37'd0, awlen, awsize, awburst, wstrb, wlast}, {37'd0, 8'd0, 3'b011, 2'b01, 8'hFF, 1'b1});
        resetn = 1'b1;
        cyc();

        // Single write from requester 1
        base = BASE;
        req_valid = 4'b0010;
        wait_grant(g);
        chk("t1_ready", 64'(req_ready), 64'h2);
        chk("t1_awaddr", awaddr, 64'h1_0000_0008);
        chk("t1_wdata", wdata, 64'hDEAD_BEEF_0123_4567);
        cyc();
        chk("t1_pulse", 64'(req_ready), 64'd0);
        wait_idle();
        chk("t1_busy_low", 64'(busy), 64'd0);

        // All requesters held: strict rotation from index 0
        do_reset();
        sticky = 1;
        req_valid = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            logic [63:0] offs [5];
            offs = '{64'h0, 64'h8, 64'h10, 64'h18, 64'h0};
            wait_grant(g);
            chk("t2_order", 64'(g), 64'(n % 4));
            chk("t2_addr", awaddr, BASE + offs[n]);
        end
        sticky = 0;
        req_valid = '0;
        wait_idle();

        // AWREADY late, WREADY immediate
        aw_delay = 3;
        b0 = b_cnt;
        req_valid = 4'b0100;
        wait_grant(g);
        chk("t3_index", 64'(g), 64'd2);
        cyc();
        chk("t3_wvalid_dropped", 64'(wvalid), 64'd0);
        chk("t3_awvalid_held", 64'(awvalid), 64'd1);
        chk("t3_awaddr_stable", awaddr, BASE + 64'h10);
        cyc(2);
        chk("t3_awvalid_still", 64'(awvalid), 64'd1);
        chk("t3_awaddr_still", awaddr, BASE + 64'h10);
        wait_idle();
        chk("t3_one_b", 64'(b_cnt - b0), 64'd1);
        aw_delay = 0;

        // Error counting and saturation
        one_write(3, 2'd2);
        one_write(0, 2'd0);
        one_write(1, 2'd2);
        chk("t4_err2", 64'(err_count), 64'd2);
        #1;
        force dut.err_q = 16'hFFFD;
        preload = 1;
        cyc();
        release dut.err_q;
        preload = 0;
        one_write(2, 2'd2);
        chk("t4_err_fffe", 64'(err_count), 64'hFFFE);
        one_write(3, 2'd3);
        one_write(0, 2'd2);
        chk("t4_err_sat", 64'(err_count), 64'hFFFF);
        bresp_cfg = 2'd0;

        // Disabled block holds off pending requests
        do_reset();
        base = '0;
        req_valid = 4'b1111;
        for (int n = 0; n < 20; n++) begin
            cyc();
            chk("t5_no_ready", 64'(req_ready), 64'd0);
            chk("t5_no_awvalid", 64'(awvalid), 64'd0);
        end
        base = 64'h8000;
        wait_grant(g);
        chk("t5_first", 64'(g), 64'd0);
        chk("t5_addr", awaddr, 64'h8000);
        for (int n = 1; n < 4; n++) begin
            wait_grant(g);
            chk("t5_rr", 64'(g), 64'(n));
        end
        wait_idle();

        // Reset while waiting for B
        one_write(0, 2'd3);
        chk("t6_err1", 64'(err_count), 64'd1);
        b_hold = 1;
        req_valid = 4'b0001;
        wait_grant(g);
        for (int t = 0; t < 10 && !bready; t++) cyc();
        chk("t6_in_resp", 64'(bready), 64'd1);
        resetn = 1'b0;
        cyc();
        chk("t6_rst_ready", 64'(req_ready), 64'd0);
        chk("t6_rst_busy", 64'(busy), 64'd0);
        chk("t6_rst_valids", {61'd0, awvalid, wvalid, bready}, 64'd0);
        chk("t6_rst_err", 64'(err_count), 64'd0);
        resetn = 1'b1;
        b_hold = 0;
        cyc();
        b0 = b_cnt;
        one_write(2, 2'd0);
        chk("t6_after_b", 64'(b_cnt - b0), 64'd1);
        chk("t6_after_err", 64'(err_count), 64'd0);

        cyc(2);
        checking = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
